msk_tof_stream_stage: RTL and testbench



---
 rtl/msk_tof_stream_stage.sv | 208 ++++++++++++++++++++
 tb/tb_msk_tof_stream_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_tof_stream_stage.sv
// Flow-controlled driver around NBITS masked HPC3 Toffoli lanes: out = (a & b) ^ c on d shares.
// Optional MSK_TOF_STREAM_FULLRATE_EN: 2-entry output FIFO, one issue per cycle.
module msk_tof_stream_stage #(
    parameter int d     = 2,
    parameter int NBITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [d*NBITS-1:0]       in_a,
    input  logic [d*NBITS-1:0]       in_b,
    input  logic [d*NBITS-1:0]       in_c,
    input  logic                     rnd_valid,
    output logic                     rnd_ready,
    input  logic [NBITS*d*(d-1)-1:0] rnd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [d*NBITS-1:0]       out_sh
);

    localparam int RND_W    = NBITS*d*(d-1);
    localparam int SH_W     = d*NBITS;
    localparam int PER_LANE = d*(d-1);

    // Unordered share pair {i,j} -> index; each pair owns bits r (2p) and r' (2p+1) of a lane slice.
    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo*d - (lo*(lo+1))/2 + (hi - lo - 1);
    endfunction

    logic                   w_fire;
    logic                   w_slot_free;
    logic                   w_vld_p1;
    logic [SH_W-1:0]        w_a_p0;
    logic [SH_W-1:0]        w_b_p0;
    logic [SH_W-1:0]        w_c_p0;
    logic [RND_W-1:0]       w_rnd_p0;
    logic [NBITS-1:0]       w_u_p0 [d][d];
    logic [NBITS-1:0]       w_v_p0 [d][d];
    logic [NBITS-1:0]       r_u_p1 [d][d];
    logic [NBITS-1:0]       r_v_p1 [d][d];
    logic [SH_W-1:0]        r_bprev_p1;
    logic [SH_W-1:0]        w_z_p1;

    assign w_fire    = in_valid & rnd_valid & w_slot_free & ~rst;
    assign in_ready  = w_fire;
    assign rnd_ready = w_fire;

    // p0: issue cycle; gadget inputs are zero unless operands and randomness are consumed now
    assign w_a_p0   = w_fire ? in_a : '0;
    assign w_b_p0   = w_fire ? in_b : '0;
    assign w_c_p0   = w_fire ? in_c : '0;
    assign w_rnd_p0 = w_fire ? rnd  : '0;

    // Diagonal keeps a_i and c_i; a_i & b_i is formed next cycle against the replayed b.
    always_comb begin
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                w_u_p0[i][j] = '0;
                w_v_p0[i][j] = '0;
                for (int l = 0; l < NBITS; l++) begin
                    if (i == j) begin
                        w_u_p0[i][j][l] = w_a_p0[i*NBITS+l];
                        w_v_p0[i][j][l] = w_c_p0[i*NBITS+l];
                    end else begin
                        w_u_p0[i][j][l] = w_a_p0[i*NBITS+l] &
                            (w_b_p0[j*NBITS+l] ^ w_rnd_p0[l*PER_LANE + 2*pair_idx(i, j)]);
                        w_v_p0[i][j][l] = (~w_a_p0[i*NBITS+l] & w_rnd_p0[l*PER_LANE + 2*pair_idx(i, j)]) ^
                            w_rnd_p0[l*PER_LANE + 2*pair_idx(i, j) + 1];
                    end
                end
            end
        end
    end

    // p1: gadget registers plus previous-cycle b; shares recombined in the in-flight cycle
    always_ff @(posedge clk) begin
        r_u_p1 <= w_u_p0;
        r_v_p1 <= w_v_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bprev_p1 <= '0;
        end else begin
            r_bprev_p1 <= w_b_p0;
        end
    end

    always_comb begin
        w_z_p1 = '0;
        for (int i = 0; i < d; i++) begin
            for (int l = 0; l < NBITS; l++) begin
                w_z_p1[i*NBITS+l] = (r_u_p1[i][i][l] & r_bprev_p1[i*NBITS+l]) ^ r_v_p1[i][i][l];
                for (int j = 0; j < d; j++) begin
                    if (j != i) begin
                        w_z_p1[i*NBITS+l] = w_z_p1[i*NBITS+l] ^ r_u_p1[i][j][l] ^ r_v_p1[i][j][l];
                    end
                end
            end
        end
    end

`ifdef MSK_TOF_STREAM_FULLRATE_EN
    logic            r_vld_p1;
    logic [1:0]      r_cnt_p2;
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [SH_W-1:0] r_mem_p2 [2];
    logic            w_push;
    logic            w_pop;

    assign w_vld_p1    = r_vld_p1;
    assign w_push      = r_vld_p1;
    assign w_pop       = (r_cnt_p2 != 2'd0) & out_ready;
    assign w_slot_free = ~((r_cnt_p2 == 2'd2) | ((r_cnt_p2 == 2'd1) & r_vld_p1 & ~out_ready));

    // p2: two-entry result FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1    <= 1'b0;
            r_cnt_p2    <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_mem_p2[0] <= '0;
            r_mem_p2[1] <= '0;
        end else begin
            r_vld_p1 <= w_fire;
            if (w_push) begin
                r_mem_p2[r_wr_ptr] <= w_z_p1;
                r_wr_ptr           <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt_p2 <= r_cnt_p2 + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign out_valid = (r_cnt_p2 != 2'd0);
    assign out_sh    = r_mem_p2[r_rd_ptr];
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLIGHT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_vld_p2;
    logic [SH_W-1:0] r_out_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = w_fire ? S_FLIGHT : S_IDLE;
            S_FLIGHT: w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = w_fire ? S_FLIGHT : S_IDLE;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_vld_p1    = 1'b0;
        w_vld_p2    = 1'b0;
        w_slot_free = 1'b0;
        case (r_state)
            S_IDLE:   w_slot_free = 1'b1;
            S_FLIGHT: w_vld_p1    = 1'b1;
            S_HOLD: begin
                w_vld_p2    = 1'b1;
                w_slot_free = out_ready;
            end
            default:  w_slot_free = 1'b0;
        endcase
    end

    // p2: single-entry output buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_p2 <= '0;
        end else if (w_vld_p1) begin
            r_out_p2 <= w_z_p1;
        end
    end

    assign out_valid = w_vld_p2;
    assign out_sh    = r_out_p2;
`endif

endmodule

// File: tb/tb_msk_tof_stream_stage.sv
// Bench for msk_tof_stream_stage: directed sequences, truth table on a d=3 lane, random traffic vs queue model.
module tb_msk_tof_stream_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready;
    logic [7:0] in_a, in_b, in_c, rnd, out_sh;

    logic       x_in_valid, x_in_ready, x_rnd_valid, x_rnd_ready, x_out_valid, x_out_ready;
    logic [2:0] x_in_a, x_in_b, x_in_c, x_out_sh;
    logic [5:0] x_rnd;

    always #5 clk = ~clk;

    msk_tof_stream_stage #(.d(2), .NBITS(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready), .out_sh(out_sh)
    );

    msk_tof_stream_stage #(.d(3), .NBITS(1)) u_dut_x (
        .clk(clk), .rst(rst),
        .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_a(x_in_a), .in_b(x_in_b), .in_c(x_in_c),
        .rnd_valid(x_rnd_valid), .rnd_ready(x_rnd_ready), .rnd(x_rnd),
        .out_valid(x_out_valid), .out_ready(x_out_ready), .out_sh(x_out_sh)
    );

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic y;
    } vec_t;

    vec_t       tv [8];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         fire_cnt = 0;
    logic [3:0] q [$];

    function automatic logic [3:0] unmask(input logic [7:0] s);
        return s[3:0] ^ s[7:4];
    endfunction

    function automatic logic [7:0] mask(input logic [3:0] v);
        logic [3:0] r;
        r = 4'($urandom);
        return {v ^ r, r};
    endfunction

    function automatic logic [2:0] mask_x(input logic v);
        logic [1:0] r;
        r = 2'($urandom);
        return {v ^ r[1] ^ r[0], r};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        in_a = mask(a);
        in_b = mask(b);
        in_c = mask(c);
        rnd  = 8'($urandom);
    endtask

    // Scoreboard: every accepted operand set yields one (a&b)^c, delivered in order; reset discards pending work.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            check("rst_in_ready", 32'(in_ready), 32'd0);
        end else begin
            check("ready_pair", 32'(in_ready), 32'(rnd_ready));
            if (in_ready) begin
                check("fire_needs_both", 32'(in_valid & rnd_valid), 32'd1);
                q.push_back((unmask(in_a) & unmask(in_b)) ^ unmask(in_c));
                fire_cnt++;
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    check("result", 32'(unmask(out_sh)), 32'(q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time %0t, expected finish before 500000", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] held;
        int         f0;
        logic       fired;

        tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tv[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
        tv[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tv[7] = '{1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; rnd = '0;
        x_in_valid = 1'b0; x_rnd_valid = 1'b0; x_out_ready = 1'b0;
        x_in_a = '0; x_in_b = '0; x_in_c = '0; x_rnd = '0;

        // Reset: nothing accepted even with both valids high
        tick(); tick();
        in_valid = 1'b1; rnd_valid = 1'b1;
        #2;
        check("rst_hold_in_ready", 32'(in_ready), 32'd0);
        check("rst_hold_rnd_ready", 32'(rnd_ready), 32'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sh", 32'(out_sh), 32'd0);
        check("rst_x_out_valid", 32'(x_out_valid), 32'd0);
        tick();

        // Basic op: A & C ^ 5 = D, two cycles after accept
        new_op(4'hA, 4'hC, 4'h5);
        in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        #2; check("basic_fire", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0; rnd_valid = 1'b0;
        #2; check("basic_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        #2; check("basic_lat2_valid", 32'(out_valid), 32'd1);
        check("basic_result", 32'(unmask(out_sh)), 32'hD);
        tick();
        #2; check("basic_drained", 32'(out_valid), 32'd0);
        tick();

        // Randomness starvation and the reverse case
        f0 = fire_cnt;
        new_op(4'($urandom), 4'($urandom), 4'($urandom));
        in_valid = 1'b1; rnd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            check("starve_in_ready", 32'(in_ready), 32'd0);
            check("starve_rnd_ready", 32'(rnd_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0; rnd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("noop_rnd_ready", 32'(rnd_ready), 32'd0);
            tick();
        end
        in_valid = 1'b1;
        #2; check("starve_fire", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0; rnd_valid = 1'b0;
        tick();
        #2; check("starve_out_valid", 32'(out_valid), 32'd1);
        tick();
        check("starve_one_fire", 32'(fire_cnt - f0), 32'd1);

`ifndef MSK_TOF_STREAM_FULLRATE_EN
        // Backpressure: pending result blocks new issues, then drain and issue in one cycle
        out_ready = 1'b0;
        new_op(4'($urandom), 4'($urandom), 4'($urandom));
        in_valid = 1'b1; rnd_valid = 1'b1;
        #2; check("bp_fire", 32'(in_ready), 32'd1);
        tick();
        new_op(4'($urandom), 4'($urandom), 4'($urandom));
        #2; check("bp_flight_block", 32'(in_ready), 32'd0);
        tick();
        held = out_sh;
        for (int k = 0; k < 6; k++) begin
            #2;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_stable", 32'(out_sh), 32'(held));
            check("bp_no_fire", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #2;
        check("bp_drain_fire", 32'(in_ready), 32'd1);
        check("bp_drain_valid", 32'(out_valid), 32'd1);
        tick(); in_valid = 1'b0; rnd_valid = 1'b0;
        #2; check("bp_gap", 32'(out_valid), 32'd0);
        tick();
        #2; check("bp_next_valid", 32'(out_valid), 32'd1);
        tick();
`endif

        // Throughput: eight cycles of continuous offer
        out_ready = 1'b1;
        f0 = fire_cnt;
        new_op(4'($urandom), 4'($urandom), 4'($urandom));
        in_valid = 1'b1; rnd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #2;
            fired = in_ready;
            tick();
            if (fired) new_op(4'($urandom), 4'($urandom), 4'($urandom));
        end
        in_valid = 1'b0; rnd_valid = 1'b0;
`ifdef MSK_TOF_STREAM_FULLRATE_EN
        check("tput_fires", 32'(fire_cnt - f0), 32'd8);
`else
        check("tput_fires", 32'(fire_cnt - f0), 32'd4);
`endif
        tick(); tick(); tick();
        check("tput_drained", 32'(q.size()), 32'd0);

        // Reset one cycle after an accept discards that operation
        new_op(4'($urandom), 4'($urandom), 4'($urandom));
        in_valid = 1'b1; rnd_valid = 1'b1;
        #2; check("rm_fire", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0; rnd_valid = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        #2;
        check("rm_out_valid", 32'(out_valid), 32'd0);
        check("rm_out_sh", 32'(out_sh), 32'd0);
        check("rm_in_ready", 32'(in_ready), 32'd0);
        check("rm_rnd_ready", 32'(rnd_ready), 32'd0);
        tick();
        #2; check("rm_no_late_valid", 32'(out_valid), 32'd0);
        tick();
        new_op(4'($urandom), 4'($urandom), 4'($urandom));
        in_valid = 1'b1; rnd_valid = 1'b1;
        #2; check("rm_next_fire", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0; rnd_valid = 1'b0;
        tick();
        #2; check("rm_next_valid", 32'(out_valid), 32'd1);
        check("rm_next_pending", 32'(q.size()), 32'd1);
        tick();
        check("rm_next_drained", 32'(q.size()), 32'd0);

        // Random traffic against the queue model
        for (int k = 0; k < 300; k++) begin
            new_op(4'($urandom), 4'($urandom), 4'($urandom));
            in_valid  = 1'($urandom_range(0, 1));
            rnd_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check("rand_drained", 32'(q.size()), 32'd0);

        // Toffoli truth table on a three-share single lane
        x_out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            x_in_a = mask_x(tv[t].a);
            x_in_b = mask_x(tv[t].b);
            x_in_c = mask_x(tv[t].c);
            x_rnd  = 6'($urandom);
            x_in_valid = 1'b1; x_rnd_valid = 1'b1;
            #2; check("x_fire", 32'(x_in_ready & x_rnd_ready), 32'd1);
            tick(); x_in_valid = 1'b0; x_rnd_valid = 1'b0;
            tick();
            #2;
            check("x_valid", 32'(x_out_valid), 32'd1);
            check("x_truth", 32'(^x_out_sh), 32'(tv[t].y));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
